// File: rtl/ack_bus_port.sv
// Per-source requester for the open-drain ack bus: queues done pulses, wins the
// bus by MSB-first bitwise arbitration, raises ack_req and holds until READY.
module ack_bus_port #(
  parameter logic [1:0]  SOURCE_ID = 2'b00,
  parameter int unsigned CNT_W     = 2,
  parameter int unsigned TIMEOUT   = 255,
  parameter int unsigned TO_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ack_event_in,
  input  logic             ack_ready,
  input  logic             ack_valid_n_bus,
  input  logic [1:0]       ack_id_bus,
  output logic             ack_valid_n_oe,
  output logic [1:0]       ack_id_oe,
  output logic             ack_req,
  output logic [CNT_W-1:0] pending_cnt,
  output logic             busy,
  output logic             overflow,
  output logic             timeout_pulse
);

  typedef enum logic [2:0] {
    IDLE,
    ARB_MSB,
    ARB_LSB,
    WAIT_READY,
    GAP
  } state_e;

  localparam logic [CNT_W-1:0] PEND_MAX = '1;
  localparam logic [CNT_W-1:0] PEND_ONE = CNT_W'(1);
  localparam logic [TO_W-1:0]  TO_ONE   = TO_W'(1);
  localparam logic [TO_W-1:0]  TO_LIMIT = TO_W'(TIMEOUT);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] pend_q, pend_d;
  logic [TO_W-1:0]  to_q, to_d;
  logic             ovf_q, ovf_d;
  logic             tmo_q, tmo_d;
  logic             voe_q, voe_d;
  logic [1:0]       id_oe_q, id_oe_d;
  logic             req_q, req_d;
  logic             busy_q, busy_d;
  logic             grant;

  assign grant = (state_q == WAIT_READY) && ack_ready;

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    to_d    = to_q;
    ovf_d   = ovf_q;
    tmo_d   = 1'b0;

    if (ack_event_in && !grant) begin
      if (pend_q == PEND_MAX) ovf_d = 1'b1;
      else                    pend_d = pend_q + PEND_ONE;
    end else if (grant && !ack_event_in) begin
      pend_d = pend_q - PEND_ONE;
    end

    case (state_q)
      IDLE: begin
        if (pend_q != '0 && ack_valid_n_bus) state_d = ARB_MSB;
      end
      ARB_MSB: begin
        state_d = (SOURCE_ID[1] && !ack_id_bus[1]) ? IDLE : ARB_LSB;
      end
      ARB_LSB: begin
        to_d    = '0;
        state_d = (SOURCE_ID[0] && !ack_id_bus[0]) ? IDLE : WAIT_READY;
      end
      WAIT_READY: begin
        to_d = to_q + TO_ONE;
        // READY takes priority over a timeout landing in the same cycle
        if (ack_ready) begin
          state_d = GAP;
        end else if (to_d == TO_LIMIT) begin
          state_d = IDLE;
          tmo_d   = 1'b1;
        end
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Drives are decoded from the next state so every output leaves a flop.
    voe_d   = 1'b0;
    id_oe_d = '0;
    req_d   = 1'b0;
    busy_d  = (state_d != IDLE);
    case (state_d)
      ARB_MSB: begin
        voe_d   = 1'b1;
        id_oe_d = {~SOURCE_ID[1], 1'b0};
      end
      ARB_LSB: begin
        voe_d   = 1'b1;
        id_oe_d = ~SOURCE_ID;
      end
      WAIT_READY: begin
        voe_d   = 1'b1;
        id_oe_d = ~SOURCE_ID;
        req_d   = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pend_q  <= '0;
      to_q    <= '0;
      ovf_q   <= 1'b0;
      tmo_q   <= 1'b0;
      voe_q   <= 1'b0;
      id_oe_q <= '0;
      req_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      to_q    <= to_d;
      ovf_q   <= ovf_d;
      tmo_q   <= tmo_d;
      voe_q   <= voe_d;
      id_oe_q <= id_oe_d;
      req_q   <= req_d;
      busy_q  <= busy_d;
    end
  end

  assign ack_valid_n_oe = voe_q;
  assign ack_id_oe      = id_oe_q;
  assign ack_req        = req_q;
  assign pending_cnt    = pend_q;
  assign busy           = busy_q;
  assign overflow       = ovf_q;
  assign timeout_pulse  = tmo_q;

endmodule

// File: tb/tb_ack_bus_port.sv
// Two ack_bus_port instances (IDs 10 and 01) on a wired-AND bus, compared each
// cycle against a per-port behavioural model; directed scenarios then random traffic.
module tb_ack_bus_port;

  localparam int         MAXP = 3;
  localparam int         TMO  = 8;
  localparam logic [1:0] ID_A = 2'b10;
  localparam logic [1:0] ID_B = 2'b01;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ev_a, ev_b, rdy_a, rdy_b;
  logic       a_voe, b_voe, a_req, b_req, a_busy, b_busy, a_ovf, b_ovf, a_to, b_to;
  logic [1:0] a_idoe, b_idoe, a_pend, b_pend;
  logic       vbus_n;
  logic [1:0] idbus;

  always #5 clk = ~clk;

  assign vbus_n = ~(a_voe | b_voe);
  assign idbus  = ~(a_idoe | b_idoe);

  ack_bus_port #(.SOURCE_ID(ID_A), .CNT_W(2), .TIMEOUT(TMO), .TO_W(8)) u_a (
    .clk(clk), .rst_n(rst_n), .ack_event_in(ev_a), .ack_ready(rdy_a),
    .ack_valid_n_bus(vbus_n), .ack_id_bus(idbus), .ack_valid_n_oe(a_voe),
    .ack_id_oe(a_idoe), .ack_req(a_req), .pending_cnt(a_pend), .busy(a_busy),
    .overflow(a_ovf), .timeout_pulse(a_to));

  ack_bus_port #(.SOURCE_ID(ID_B), .CNT_W(2), .TIMEOUT(TMO), .TO_W(8)) u_b (
    .clk(clk), .rst_n(rst_n), .ack_event_in(ev_b), .ack_ready(rdy_b),
    .ack_valid_n_bus(vbus_n), .ack_id_bus(idbus), .ack_valid_n_oe(b_voe),
    .ack_id_oe(b_idoe), .ack_req(b_req), .pending_cnt(b_pend), .busy(b_busy),
    .overflow(b_ovf), .timeout_pulse(b_to));

  // ph: 0 idle, 1 msb arbitration, 2 lsb arbitration, 3 waiting for READY, 4 gap
  typedef struct {
    int ph;
    int waited;
    int pend;
    bit ovf;
    bit top;
  } port_m_t;

  port_m_t ma, mb;
  int      passed = 0;
  int      fails  = 0;
  int      total  = 0;
  int      mode_a = 0;
  int      mode_b = 0;
  bit      rand_ev = 1'b0;

  function automatic void drives(input port_m_t m, input logic [1:0] id,
                                 output logic voe, output logic [1:0] idoe);
    voe  = (m.ph >= 1 && m.ph <= 3);
    idoe = (m.ph == 1) ? {~id[1], 1'b0} : (m.ph == 2 || m.ph == 3) ? ~id : 2'b00;
  endfunction

  function automatic port_m_t step(input port_m_t m, input logic [1:0] id, input bit ev,
                                   input bit rdy, input bit vb_n, input logic [1:0] idb);
    port_m_t n;
    bit      take;
    n     = m;
    take  = (m.ph == 3) && rdy;
    n.top = 1'b0;
    n.pend = m.pend + int'(ev) - int'(take);
    if (n.pend > MAXP) begin
      n.pend = MAXP;
      n.ovf  = 1'b1;
    end
    if (m.ph == 0)      n.ph = (m.pend != 0 && vb_n) ? 1 : 0;
    else if (m.ph == 1) n.ph = (id[1] && !idb[1]) ? 0 : 2;
    else if (m.ph == 2) begin
      n.ph     = (id[0] && !idb[0]) ? 0 : 3;
      n.waited = 0;
    end else if (m.ph == 3) begin
      n.waited = m.waited + 1;
      if (take) n.ph = 4;
      else if (n.waited == TMO) begin
        n.ph  = 0;
        n.top = 1'b1;
      end
    end else n.ph = 0;
    return n;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_port(input string p, input port_m_t m, input logic [1:0] id,
                          input logic voe, input logic [1:0] idoe, input logic [1:0] pend,
                          input logic req, input logic bsy, input logic ovf, input logic to);
    logic       ev;
    logic [1:0] ei;
    drives(m, id, ev, ei);
    chk({p, ".pend"}, 32'(pend), 32'(m.pend));
    chk({p, ".voe"},  32'(voe),  32'(ev));
    chk({p, ".idoe"}, 32'(idoe), 32'(ei));
    chk({p, ".req"},  32'(req),  32'(m.ph == 3));
    chk({p, ".busy"}, 32'(bsy),  32'(m.ph != 0));
    chk({p, ".ovf"},  32'(ovf),  32'(m.ovf));
    chk({p, ".to"},   32'(to),   32'(m.top));
  endtask

  task automatic check_all();
    chk_port("a", ma, ID_A, a_voe, a_idoe, a_pend, a_req, a_busy, a_ovf, a_to);
    chk_port("b", mb, ID_B, b_voe, b_idoe, b_pend, b_req, b_busy, b_ovf, b_to);
  endtask

  task automatic tick();
    logic       va, vb;
    logic [1:0] ia, ib;
    drives(ma, ID_A, va, ia);
    drives(mb, ID_B, vb, ib);
    @(posedge clk);
    ma = step(ma, ID_A, ev_a, rdy_a, ~(va | vb), ~(ia | ib));
    mb = step(mb, ID_B, ev_b, rdy_b, ~(va | vb), ~(ia | ib));
    #1;
    check_all();
    ev_a = 1'b0;
    ev_b = 1'b0;
    if (rand_ev) begin
      ev_a = ($urandom_range(0, 4) == 0);
      ev_b = ($urandom_range(0, 4) == 0);
    end
    rdy_a = (mode_a == 2) ? ($urandom_range(0, 1) == 1) : (mode_a == 1 && ma.ph == 3);
    rdy_b = (mode_b == 2) ? ($urandom_range(0, 1) == 1) : (mode_b == 1 && mb.ph == 3);
  endtask

  initial begin
    int  lat, nreq, grants, first;
    bit  found;
    ev_a = 1'b0; ev_b = 1'b0; rdy_a = 1'b0; rdy_b = 1'b0;
    ma = '{default: 0};
    mb = '{default: 0};

    // reset state
    repeat (2) @(posedge clk);
    #1;
    check_all();
    rst_n = 1'b1;
    tick();

    // single event, immediate grant: latency and drive pattern
    mode_b = 1;
    ev_b   = 1'b1;
    tick();
    found = 1'b0;
    lat   = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      tick();
      lat++;
      if (lat == 1) chk("t1.msb_idoe", 32'(b_idoe), 32'(2'b10));
      if (b_req) found = 1'b1;
    end
    chk("t1.req_seen", 32'(found), 32'(1));
    chk("t1.req_latency", 32'(lat), 32'(3));
    tick();
    chk("t1.pend_after_grant", 32'(b_pend), 32'(0));
    chk("t1.gap_voe", 32'(b_voe), 32'(0));
    chk("t1.gap_busy", 32'(b_busy), 32'(1));
    tick();
    chk("t1.idle_busy", 32'(b_busy), 32'(0));

    // contention: ID 01 must be granted first, ID 10 afterwards
    mode_a = 1;
    ev_a   = 1'b1;
    ev_b   = 1'b1;
    first  = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (first == 0 && b_req) first = 2;
      if (first == 0 && a_req) first = 1;
    end
    chk("t2.first_winner", 32'(first), 32'(2));
    chk("t2.a_pend", 32'(a_pend), 32'(0));
    chk("t2.b_pend", 32'(b_pend), 32'(0));

    // saturation and sticky overflow
    mode_a = 0;
    for (int i = 0; i < 4; i++) begin
      ev_a = 1'b1;
      tick();
    end
    chk("t3.pend_sat", 32'(a_pend), 32'(3));
    chk("t3.ovf_set", 32'(a_ovf), 32'(1));
    mode_a = 1;
    grants = 0;
    for (int i = 0; i < 60; i++) begin
      if (a_req && rdy_a) grants++;
      tick();
    end
    chk("t3.grants", 32'(grants), 32'(3));
    chk("t3.pend_drained", 32'(a_pend), 32'(0));
    chk("t3.ovf_sticky", 32'(a_ovf), 32'(1));

    // timeout after TMO waiting cycles
    mode_b = 0;
    ev_b   = 1'b1;
    tick();
    found = 1'b0;
    nreq  = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      if (b_to) found = 1'b1;
      else if (b_req) nreq++;
    end
    chk("t4.timeout_seen", 32'(found), 32'(1));
    chk("t4.wait_cycles", 32'(nreq), 32'(TMO));
    chk("t4.req_released", 32'(b_req), 32'(0));
    chk("t4.pend_kept", 32'(b_pend), 32'(1));
    tick();
    chk("t4.pulse_width", 32'(b_to), 32'(0));
    chk("t4.rearb_voe", 32'(b_voe), 32'(1));
    mode_b = 1;
    repeat (10) tick();
    chk("t4.pend_drained", 32'(b_pend), 32'(0));

    // event and READY in the same cycle
    mode_b = 0;
    ev_b   = 1'b1;
    tick();
    ev_b = 1'b1;
    tick();
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      tick();
      if (b_req) found = 1'b1;
    end
    chk("t5.req_seen", 32'(found), 32'(1));
    ev_b  = 1'b1;
    rdy_b = 1'b1;
    tick();
    chk("t5.pend_same", 32'(b_pend), 32'(2));
    chk("t5.gap_voe", 32'(b_voe), 32'(0));
    mode_b = 1;
    repeat (20) tick();
    chk("t5.pend_drained", 32'(b_pend), 32'(0));

    // asynchronous reset while waiting for READY
    mode_b = 0;
    ev_b   = 1'b1;
    tick();
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      tick();
      if (b_req) found = 1'b1;
    end
    chk("t6.req_seen", 32'(found), 32'(1));
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6.rst_req", 32'(b_req), 32'(0));
    chk("t6.rst_voe", 32'(b_voe), 32'(0));
    chk("t6.rst_idoe", 32'(b_idoe), 32'(0));
    chk("t6.rst_busy", 32'(b_busy), 32'(0));
    chk("t6.rst_pend", 32'(b_pend), 32'(0));
    ma = '{default: 0};
    mb = '{default: 0};
    ev_a = 1'b0; ev_b = 1'b0; rdy_a = 1'b0; rdy_b = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (5) tick();
    chk("t6.stay_idle", 32'(b_busy), 32'(0));

    // random traffic, READY also toggled outside WAIT_READY
    rand_ev = 1'b1;
    mode_a  = 2;
    mode_b  = 2;
    repeat (400) tick();
    rand_ev = 1'b0;
    mode_a  = 1;
    mode_b  = 1;
    repeat (80) tick();
    chk("rnd.a_drained", 32'(a_pend), 32'(0));
    chk("rnd.b_drained", 32'(b_pend), 32'(0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/ack_bus_port.md
Name: ack_bus_port

Overview:
- Per-module requester that sits directly upstream of the ack bus arbiter, one instance per bus source (mem, sha, aes, ctrl).
- Converts the module's "transaction done" pulses into ack requests.
- Wins the open-drain ack bus through a two-phase, MSB-first bitwise arbitration, then raises the sideband request.
- Holds the bus until the arbiter returns READY, then releases it for one gap cycle.

Parameters:
SOURCE_ID, 2'b00, this port's bus ID (00 mem, 01 sha, 10 aes, 11 ctrl); a lower ID wins.
CNT_W, 2, width of the pending-ack counter; the counter saturates at 2^CNT_W-1.
TIMEOUT, 255, number of WAIT_READY cycles without READY before the port abandons the attempt; must be >= 1.
TO_W, 8, width of the timeout counter; must satisfy 2^TO_W > TIMEOUT.

Ports:
clk  input  1  system clock; all state changes on the rising edge.
rst_n  input  1  asynchronous, active-low reset.
ack_event_in  input  1  one-cycle pulse from the module datapath; queues one ack.
ack_ready  input  1  grant from the arbiter; sampled only in WAIT_READY.
ack_valid_n_bus  input  1  resolved bus valid; 0 means someone is driving.
ack_id_bus  input  2  resolved bus ID.
ack_valid_n_oe  output  1  1 = pull ack_valid_n low.
ack_id_oe  output  2  per bit, 1 = pull that ID bit low.
ack_req  output  1  sideband request to the arbiter.
pending_cnt  output  CNT_W  number of queued acks.
busy  output  1  1 whenever the state is not IDLE.
overflow  output  1  sticky; an event was dropped at saturation.
timeout_pulse  output  1  one-cycle pulse when an attempt times out.

Behaviour:
- Reset: all outputs are 0 and the state is IDLE, asynchronously on rst_n low. Reset in any state releases the bus immediately.
- All outputs are registered. No combinational path exists from any input to any output.
- Pending counter:
  - ack_event_in alone: +1.
  - Accepted READY alone: -1.
  - Both in the same cycle: count unchanged.
  - Event while the count is at its maximum and no READY that cycle: event dropped, overflow set. Overflow clears only on reset.
- States: IDLE, ARB_MSB, ARB_LSB, WAIT_READY, GAP.
- IDLE: all drives are 0.
  - Go to ARB_MSB when pending_cnt != 0 and ack_valid_n_bus == 1 in the same cycle.
  - If the bus is busy, stay in IDLE.
  - Ports that see the idle bus in the same cycle proceed in lockstep.
- ARB_MSB (1 cycle):
  - Drives: valid_oe=1, id_oe[1]=~SOURCE_ID[1], id_oe[0]=0.
  - At the next edge, if SOURCE_ID[1]==1 and ack_id_bus[1]==0: lost, go to IDLE with all drives released.
  - Otherwise go to ARB_LSB.
- ARB_LSB (1 cycle):
  - Drives: valid_oe=1, id_oe=~SOURCE_ID.
  - At the next edge, if SOURCE_ID[0]==1 and ack_id_bus[0]==0: lost, go to IDLE with drives released.
  - Otherwise go to WAIT_READY.
- WAIT_READY:
  - Drives: valid_oe=1, id_oe=~SOURCE_ID, ack_req=1.
  - The timeout counter clears on entry and increments each cycle.
  - On ack_ready=1: the pending count decrements and the next state is GAP.
  - If the counter reaches TIMEOUT with no READY: timeout_pulse=1 for one cycle, drives released, return to IDLE with the pending count unchanged.
  - If READY and timeout occur in the same cycle, READY wins.
- GAP (1 cycle): all drives released, ack_req=0. Next state is IDLE, which guarantees the bus returns high between grants.
- ack_req is 1 only in WAIT_READY. ack_ready in any other state is ignored.
- A losing port retries after the winner's GAP cycle.
- Minimum latency:
  - pending_cnt becomes nonzero at edge k.
  - ARB_MSB drive is visible after edge k+1.
  - WAIT_READY / ack_req are visible after edge k+3.
  - With an immediate grant, pending decrements at edge k+4.

Test Plan:
1. SOURCE_ID=01, single event pulse, bus otherwise idle -> ARB_MSB drives valid_oe=1, id_oe=10; ARB_LSB drives id_oe=10; WAIT_READY drives ack_req=1. READY on the first WAIT_READY cycle -> pending 1->0, one GAP cycle with oe=0, back to IDLE, busy=0.
2. Two instances (ID 10 and ID 01) plus a bus wired-AND model, events in the same cycle -> ID 10 releases after ARB_MSB; ID 01 completes and gets READY. ID 10 restarts after the GAP, wins, and is granted. Both pending counts end at 0.
3. CNT_W=2, four event pulses with no READY -> pending_cnt=3, overflow=1 (sticky). Then exactly three grants drain the count to 0, and overflow stays 1.
4. TIMEOUT=8, ack_ready tied 0 -> timeout_pulse high for exactly one cycle on the 8th WAIT_READY cycle, drives released, pending unchanged, new ARB_MSB once the bus is idle.
5. ack_event_in and ack_ready in the same cycle with pending=2 -> pending stays 2. A second attempt follows after GAP.
6. rst_n asserted mid-WAIT_READY -> oe, ack_req, busy and pending_cnt all 0 immediately, without waiting for a clock edge. After release, the port stays IDLE until a new event arrives.
